stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 20: consecutive stable samples required to accept a button level.
REQ-002 Parameter TICK_DIV, default 10: clk cycles per count-enable tick (1 kHz clk gives a 10 ms tick).
REQ-003 clk  in  1  system clock, 1 kHz nominal.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 btn_start  in  1  raw start/stop push-button, active-high, asynchronous to clk.
REQ-006 btn_lap  in  1  raw lap push-button, active-high, asynchronous to clk.
REQ-007 btn_clr  in  1  raw clear push-button, active-high, asynchronous to clk.
REQ-008 cnt_en  out  1  one-cycle advance pulse to the stopwatch digit counter.
REQ-009 cnt_clr  out  1  one-cycle clear pulse to the digit counter.
REQ-010 disp_hold  out  1  freeze the display latch; counter keeps running.
REQ-011 state  out  2  current FSM state encoding.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter that accepts a new level only after DB_CYCLES consecutive equal samples.
REQ-013 A rising edge of the debounced level SHALL produce a one-cycle press pulse.
REQ-014 Raw edge to press pulse latency SHALL be 2 + DB_CYCLES + 1 cycles.
REQ-015 FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-016 IDLE: start -> RUN; clr -> cnt_clr pulse, remain IDLE; lap ignored.
REQ-017 RUN: start -> PAUSE; lap -> LAP; clr ignored.
REQ-018 LAP: lap -> RUN; start -> PAUSE; clr ignored; disp_hold=1 only in LAP.
REQ-019 PAUSE: start -> RUN; clr -> IDLE with cnt_clr pulse; lap ignored.
REQ-020 Presses in the same cycle SHALL be prioritised clr > start > lap; lower-priority presses are discarded, not queued.
REQ-021 A state transition SHALL take effect on the clk edge following the press pulse; all outputs are registered.
REQ-022 Prescaler counts 0..TICK_DIV-1 only in RUN or LAP; cnt_en asserts for one cycle when the prescaler wraps from TICK_DIV-1 to 0.
REQ-023 Prescaler SHALL hold its value in PAUSE, so the fractional tick is preserved across pause/resume.
REQ-024 Prescaler SHALL clear to 0 in the same cycle cnt_clr asserts.
REQ-025 cnt_en and cnt_clr SHALL never assert in the same cycle.

Reset
REQ-026 On rst: state=IDLE, prescaler=0, debounced levels=0, synchronizers=0, cnt_en=0, cnt_clr=0, disp_hold=0.
REQ-027 rst asserted mid-count or mid-debounce SHALL abandon the operation, with no pulse emitted after release.
REQ-028 A button held through rst release SHALL produce a press only after a full debounce interval.

Configuration
REQ-029 Macro SW_LAP_EN defined: LAP state and the btn_lap path are implemented as above.
REQ-030 SW_LAP_EN undefined: btn_lap is ignored, its debouncer is omitted, LAP is unreachable, and disp_hold is tied 0.

Structure
REQ-031 Shared package stopwatch_pkg SHALL hold the state enum (IDLE/RUN/PAUSE/LAP) and the defaults for DB_CYCLES and TICK_DIV.
REQ-032 A sub-module sw_debounce (synchronizer + debounce + edge pulse) SHALL be instantiated once per button.

Verification (DB_CYCLES=4, TICK_DIV=10)
REQ-033 Press btn_start for 10 cycles from IDLE -> press pulse 7 cycles after edge, state=RUN next cycle, first cnt_en 10 cycles later, then every 10 cycles.
REQ-034 Glitch btn_start high for 3 cycles -> no press pulse, state unchanged.
REQ-035 RUN, prescaler=6, press start -> state=PAUSE, no cnt_en; press start again -> first cnt_en arrives 4 cycles after re-entering RUN.
REQ-036 RUN, press lap -> state=LAP, disp_hold=1, cnt_en continues; press lap -> state=RUN, disp_hold=0.
REQ-037 PAUSE, press btn_clr and btn_start in the same cycle -> cnt_clr pulses once, state=IDLE, prescaler=0.
REQ-038 Assert rst during RUN with btn_start held high -> all outputs 0, state=IDLE; no press until 7 cycles after rst release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StLap   = 2'd3
  } sw_state_e;

  localparam int unsigned DefaultDbCycles = 20;
  localparam int unsigned DefaultTickDiv  = 10;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-button front end: 2-flop synchronizer, stable-sample debouncer and rising-edge pulse.
module sw_debounce import stopwatch_pkg::*; #(
  parameter int unsigned DB_CYCLES = DefaultDbCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = cnt_width(DB_CYCLES);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            level_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn};
      level_dly_q <= level_q;
      press       <= level_q & ~level_dly_q;
      // Any sample matching the accepted level restarts the stability run.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with debounced buttons and tick prescaler.
// Define SW_LAP_EN to build the lap button path and the LAP (display hold) state.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int unsigned DB_CYCLES = DefaultDbCycles,
  parameter int unsigned TICK_DIV  = DefaultTickDiv
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam int unsigned PreW = cnt_width(TICK_DIV);
`ifdef SW_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  sw_state_e       state_q;
  logic [PreW-1:0] pre_q;
  logic            hold_q;
  logic            press_start, press_lap, press_clr;
  logic            go_start, go_lap, go_clr;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start),
    .press (press_start)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clr),
    .press (press_clr)
  );

`ifdef SW_LAP_EN
  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_lap),
    .press (press_lap)
  );
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign press_lap      = 1'b0;
`endif

  // Only the highest-priority press of a cycle is acted on; the rest are dropped.
  always_comb begin
    go_clr   = press_clr;
    go_start = press_start & ~press_clr;
    go_lap   = press_lap & ~press_start & ~press_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pre_q   <= '0;
      hold_q  <= 1'b0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      // Prescaler freezes outside RUN/LAP so a pause keeps the partial tick.
      if (state_q == StRun || state_q == StLap) begin
        if (pre_q == PreW'(TICK_DIV - 1)) begin
          pre_q  <= '0;
          cnt_en <= 1'b1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (go_clr) begin
            cnt_clr <= 1'b1;
            pre_q   <= '0;
          end else if (go_start) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (go_start) begin
            state_q <= StPause;
          end else if (go_lap) begin
            state_q <= StLap;
            hold_q  <= 1'b1;
          end
        end
        StPause: begin
          if (go_clr) begin
            state_q <= StIdle;
            cnt_clr <= 1'b1;
            pre_q   <= '0;
          end else if (go_start) begin
            state_q <= StRun;
          end
        end
        StLap: begin
          if (go_start) begin
            state_q <= StPause;
            hold_q  <= 1'b0;
          end else if (go_lap) begin
            state_q <= StRun;
            hold_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign state     = state_q;
  assign disp_hold = LapEn ? hold_q : 1'b0;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_CYCLES=4, TICK_DIV=10.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

`ifdef SW_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic       cnt_en, cnt_clr, disp_hold;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int clr_seen = 0;

  stopwatch_ctrl #(.DB_CYCLES(4), .TICK_DIV(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .btn_clr   (btn_clr),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_hold (disp_hold),
    .state     (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // cnt_en and cnt_clr must never coincide.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (cnt_en && cnt_clr) begin
        failures++;
        $display("FAIL en_clr_exclusive actual=1 required=0 at cycle %0d", cyc);
      end
      if (cnt_clr) clr_seen++;
    end
  end

  typedef struct {
    string     name;
    logic [2:0] btn;  // {clr, start, lap}
    int        hold;
    sw_state_e exp_state;
    logic      exp_hold;
    int        exp_clr;
  } vec_t;

  function automatic vec_t mk(string n, logic [2:0] b, int h, sw_state_e s, logic d, int c);
    vec_t v;
    v.name = n; v.btn = b; v.hold = h; v.exp_state = s; v.exp_hold = d; v.exp_clr = c;
    return v;
  endfunction

  vec_t      vecs[14];
  sw_state_e lap_st;
  int        c0, x, t_run1, t_run2, first_run;
  int        en_t[$];
  int        exp_en[5];

  initial begin
    lap_st = LapEn ? StLap : StRun;
    vecs[0]  = mk("idle_lap_ignored",  3'b001, 10, StIdle,  1'b0,  0);
    vecs[1]  = mk("idle_clr",          3'b100, 10, StIdle,  1'b0,  1);
    vecs[2]  = mk("glitch_start",      3'b010,  3, StIdle,  1'b0,  0);
    vecs[3]  = mk("idle_start",        3'b010, 10, StRun,   1'b0,  0);
    vecs[4]  = mk("run_clr_ignored",   3'b100, 10, StRun,   1'b0,  0);
    vecs[5]  = mk("run_lap",           3'b001, 10, lap_st,  LapEn, 0);
    vecs[6]  = mk("lap_clr_ignored",   3'b100, 10, lap_st,  LapEn, 0);
    vecs[7]  = mk("lap_start",         3'b010, 10, StPause, 1'b0,  0);
    vecs[8]  = mk("pause_lap_ignored", 3'b001, 10, StPause, 1'b0,  0);
    vecs[9]  = mk("pause_start",       3'b010, 10, StRun,   1'b0,  0);
    vecs[10] = mk("run_lap2",          3'b001, 10, lap_st,  LapEn, 0);
    vecs[11] = mk("lap_lap",           3'b001, 10, StRun,   1'b0,  0);
    vecs[12] = mk("run_start",         3'b010, 10, StPause, 1'b0,  0);
    vecs[13] = mk("pause_clr_start",   3'b110, 10, StIdle,  1'b0,  1);
    exp_en = '{18, 28, 38, 82, 92};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_state", state, StIdle);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    check("rst_disp_hold", disp_hold, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: raise buttons, hold, release, settle 20 cycles from raise, then compare.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      #1;
      c0 = clr_seen;
      {btn_clr, btn_start, btn_lap} = vecs[i].btn;
      repeat (vecs[i].hold) @(negedge clk);
      {btn_clr, btn_start, btn_lap} = 3'b000;
      repeat (20 - vecs[i].hold) @(negedge clk);
      #1;
      check({vecs[i].name, "_state"}, state, vecs[i].exp_state);
      check({vecs[i].name, "_hold"}, disp_hold, vecs[i].exp_hold);
      check({vecs[i].name, "_clr"}, clr_seen - c0, vecs[i].exp_clr);
    end

    // Latency, tick period, pause mid-tick (prescaler at 6) and resume.
    t_run1 = -1;
    t_run2 = -1;
    @(negedge clk);
    x = cyc;
    btn_start = 1'b1;
    for (int k = 1; k <= 95; k++) begin
      @(negedge clk);
      if (cyc - x != k) check("cycle_track", cyc - x, k);
      if (cnt_en) en_t.push_back(k);
      if (state == StRun && t_run1 < 0) t_run1 = k;
      if (k >= 70 && state == StRun && t_run2 < 0) t_run2 = k;
      if (k == 43) check("run_before_pause", state, StRun);
      if (k == 44) check("pause_entered", state, StPause);
      if (k == 69) check("pause_held", state, StPause);
      if (k == 10 || k == 46 || k == 80) btn_start = 1'b0;
      if (k == 36 || k == 70) btn_start = 1'b1;
    end
    check("start_to_run_latency", t_run1, 8);
    check("resume_latency", t_run2, 78);
    check("cnt_en_count", en_t.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("cnt_en_time_%0d", i), (i < en_t.size()) ? en_t[i] : -1, exp_en[i]);
    end

    // Reset mid-debounce during RUN with start held through release.
    @(negedge clk);
    btn_start = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_state", state, StIdle);
    check("midrst_cnt_en", cnt_en, 0);
    check("midrst_cnt_clr", cnt_clr, 0);
    check("midrst_disp_hold", disp_hold, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first_run = -1;
    c0 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (cnt_en) c0++;
      if (state != StIdle && first_run < 0) first_run = k;
    end
    check("post_rst_press_latency", first_run, 8);
    check("post_rst_no_cnt_en", c0, 0);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
